router_rx_sink: RTL and testbench
=================================

# router_rx_sink

Output-side consumer for one router destination port. Watches the port's `vld_out` flag and drives its `read_enb`. Unpacks each `{len[5:0],addr[1:0]}` / payload / parity packet into a byte stream. Checks the address, length and XOR parity, and keeps per-port packet and error statistics. One instance sits behind each `data_out_N` of `router_top` in the system.

## Interface
- `PORT_ID`, 2'd1, the address this instance expects in `header[1:0]`.
- `START_DELAY`, 2, number of idle cycles between seeing `vld_out_i` and issuing the header read (0..15).
- `TIMEOUT`, 64, maximum consecutive cycles with `vld_out_i` low inside a packet before the packet is aborted (2..255).
- `clk` in 1: the single clock; all logic is on the rising edge.
- `resetn` in 1: reset, synchronous, active-low.
- `vld_out_i` in 1: router port FIFO is not empty.
- `data_in` in 8: router `data_out_N`.
- `read_enb_o` out 1: router `read_enb[N]`.
- `sink_ready` in 1: downstream can accept bytes.
- `byte_valid` out 1: `byte_data` is valid this cycle.
- `byte_data` out 8: the unpacked byte (header, then payload, then parity).
- `byte_last` out 1: marks the parity byte.
- `pkt_done` out 1: one-cycle pulse at the end of a packet.
- `pkt_ok` out 1: the finished packet had no errors; valid with `pkt_done`.
- `err_parity`, `err_addr`, `err_len`, `err_timeout` out 1 each: error flags; valid with `pkt_done`.
- `pkt_len` out 6: payload length from the header; held until the next header.
- `pkt_count` out 16: number of completed packets; wraps.
- `err_count` out 8: number of packets with any error; saturates at 255.

## Operation
- **FSM states:** IDLE, DELAY, HDR_RD, HDR_CAP, BODY, FINISH.
- **IDLE:** when `vld_out_i`=1, go to DELAY and load the delay counter with START_DELAY. If START_DELAY=0, go straight to HDR_RD.
- **DELAY:** decrement the counter; at 0, go to HDR_RD.
- **HDR_RD:** `read_enb_o` = `vld_out_i & sink_ready`. When it fires, go to HDR_CAP.
- **HDR_CAP:**
  - Capture the header into `pkt_len` and the address register.
  - Load `remaining` = len+1 (payload plus parity) and `parity_acc` = header.
  - Go to BODY.
- **BODY issue side:** `read_enb_o` = `vld_out_i & sink_ready & (issue_rem!=0)`. `issue_rem` decrements on each read.
- **BODY capture side:**
  - Every byte captured with `cap_rem`>1 is XORed into `parity_acc`.
  - The byte captured with `cap_rem`==1 is the parity byte; compare it with `parity_acc`.
- **FINISH:** pulse `pkt_done`, update the counters, return to IDLE.
- **Read capture:** `data_in` is sampled on the edge after the edge at which `read_enb_o` was high (registered `rd_d`). Captures use `rd_d` only, never `vld_out_i`.
- **Byte output:** `byte_valid`/`byte_data` are registered from the capture. Every byte is emitted, including header and parity.
- **Error flags:**
  - `err_addr`: `header[1:0]` != PORT_ID. The packet is still fully drained.
  - `err_len`: len==0. Only the parity byte is read.
  - `err_parity`: `parity_acc` != parity byte.
  - `pkt_ok` = no flag set.
- **Timeout:**
  - Applies in HDR_CAP/BODY while `issue_rem`>0.
  - A counter increments each cycle `vld_out_i`=0 and clears when `vld_out_i`=1.
  - Reaching TIMEOUT sets `err_timeout`, asserts `byte_last` on no byte (`byte_valid`=0), and goes to FINISH. Any read still in flight is discarded.
- **Counters:** `pkt_count` increments by 1 on every `pkt_done`, wrapping 16'hFFFF→0. `err_count` increments when `pkt_ok`=0 and holds at 255.

## Timing
- **Reset values:** all outputs 0 after the first `resetn`=0 edge: `read_enb_o`, `byte_*`, `pkt_*`, `err_*`, counters; FSM in IDLE.
- **Reset mid-packet:** identical to power-on reset. The partial packet is dropped and no `pkt_done` is issued.
- **Start latency:** `vld_out_i` rises before edge E0 → earliest header read at edge E0+START_DELAY+1.
- **Read-to-output latency:** read at edge E → `data_in` sampled at E+1 → `byte_valid` high in the cycle after E+1.
- **Throughput:**
  - One bubble between the header read and the first payload read (HDR_CAP).
  - After that, one byte per cycle while `vld_out_i` and `sink_ready` are high.
- **`sink_ready`:** gates issue only. After `sink_ready` falls, one in-flight byte can still appear, and downstream must accept it.
- **`vld_out_i` drop:** `read_enb_o` goes low in the same cycle (combinational) and reads resume with no data loss.
- **`pkt_done`:**
  - Normal end: pulses in the same cycle as `byte_valid`/`byte_last` for the parity byte. Flags, `pkt_ok` and the updated counts are visible in that cycle; the counts are registered one cycle later and held.
  - Timeout: pulses one cycle after the timeout is detected.
- **Back-to-back packets:** the next packet may start in the IDLE cycle after FINISH.
- **Total reads per packet:** exactly len+2, never more. A following packet already in the FIFO is never touched.

## Test plan
- **Good packet:** PORT_ID=1, START_DELAY=2, header 8'h39 (len 14, addr 1), 14 random bytes, correct parity, `vld_out_i` held high → exactly 16 `read_enb_o` pulses, 16 `byte_valid` bytes in order, `byte_last` on the 16th, `pkt_done` with `pkt_ok`=1, `pkt_len`=14, `pkt_count`=1.
- **Parity error:** len 8, parity byte XOR 8'h01 → `err_parity`=1, `pkt_ok`=0, `err_count`=1, 10 reads; the next good packet gives `pkt_ok`=1.
- **Address and length errors:** header {6'd2, 2'd2} gives `err_addr`=1 with 4 reads. Header 8'h01 (len 0) gives `err_len`=1 with 2 reads.
- **Stall and timeout:** `vld_out_i` low for 5 cycles mid-payload of len 17 → `read_enb_o` low for those 5 cycles, packet ok. Low for TIMEOUT cycles → `err_timeout`=1, `pkt_done` pulse, FSM back in IDLE.
- **Backpressure:** `sink_ready` low for 3 cycles mid-payload → no reads during the stall, at most 1 trailing `byte_valid`, no byte lost or duplicated.
- **Reset mid-payload:** `resetn`=0 for one edge during byte 5 of len 15 → all outputs 0 and counters 0. The following len 8 packet completes with `pkt_count`=1.

Source files
------------

// File: rtl/router_rx_sink.sv
// router_rx_sink: drains one router output port, unpacks header/payload/parity into a byte stream and checks it
//   clk, resetn          rising-edge clock, synchronous active-low reset
//   vld_out_i, data_in   router port not-empty flag and data_out_N (data valid the edge after a read)
//   read_enb_o           router read_enb[N]
//   sink_ready           downstream may accept bytes (gates read issue only)
//   byte_valid/data/last unpacked byte stream, last marks the parity byte (or a timeout)
//   pkt_done, pkt_ok     end-of-packet pulse and error-free status
//   err_*                parity/address/length/timeout flags, valid with pkt_done
//   pkt_len              payload length of the latest header
//   pkt_count, err_count completed packets (wraps), errored packets (saturates)
module router_rx_sink #(
   parameter logic [1:0] PORT_ID     = 2'd1,
   parameter int         START_DELAY = 2,
   parameter int         TIMEOUT     = 64
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        vld_out_i,
   input  logic [7:0]  data_in,
   output logic        read_enb_o,
   input  logic        sink_ready,
   output logic        byte_valid,
   output logic [7:0]  byte_data,
   output logic        byte_last,
   output logic        pkt_done,
   output logic        pkt_ok,
   output logic        err_parity,
   output logic        err_addr,
   output logic        err_len,
   output logic        err_timeout,
   output logic [5:0]  pkt_len,
   output logic [15:0] pkt_count,
   output logic [7:0]  err_count
);
   typedef enum logic [2:0] {IDLE, DELAY, HDR_RD, HDR_CAP, BODY, FINISH} state_t;
   state_t      state, state_nx;
   logic        rd_d;
   logic [3:0]  dly_cnt;
   logic [6:0]  issue_rem, cap_rem;
   logic [7:0]  parity_acc, tmo_cnt;
   logic [15:0] pkt_cnt_q;
   logic [7:0]  err_cnt_q;
   logic        tmo_act, tmo_hit, cap_body, cap_par;
   // the timeout only watches while reads are still owed; once all are issued the data is already in flight
   assign tmo_act  = (state == HDR_CAP) || (state == BODY && issue_rem != 7'd0);
   assign tmo_hit  = tmo_act && !vld_out_i && tmo_cnt == 8'(TIMEOUT - 1);
   assign cap_body = (state == BODY) && rd_d;
   assign cap_par  = cap_body && cap_rem == 7'd1;
   always_ff @(posedge clk)
      if (!resetn) state <= IDLE;
      else         state <= state_nx;
   always_comb begin
      state_nx   = state;
      read_enb_o = 1'b0;
      case (state)
         IDLE:    state_nx = vld_out_i ? (START_DELAY == 0 ? HDR_RD : DELAY) : IDLE;
         DELAY:   state_nx = dly_cnt <= 4'd1 ? HDR_RD : DELAY;
         HDR_RD: begin
            read_enb_o = vld_out_i & sink_ready;
            state_nx   = (vld_out_i & sink_ready) ? HDR_CAP : HDR_RD;
         end
         HDR_CAP: state_nx = BODY;
         BODY: begin
            read_enb_o = vld_out_i & sink_ready & (issue_rem != 7'd0);
            state_nx   = (tmo_hit | cap_par) ? FINISH : BODY;
         end
         default: state_nx = IDLE;
      endcase
   end
   // counts are shown already incremented during the pkt_done cycle and registered at its end
   always_comb begin
      pkt_done  = state == FINISH;
      pkt_ok    = pkt_done & ~(err_parity | err_addr | err_len | err_timeout);
      pkt_count = pkt_cnt_q + {15'd0, pkt_done};
      err_count = err_cnt_q + {7'd0, pkt_done & ~pkt_ok & (err_cnt_q != 8'hFF)};
   end
   always_ff @(posedge clk)
      if (!resetn) begin
         rd_d        <= 1'b0;
         dly_cnt     <= 4'd0;
         issue_rem   <= 7'd0;
         cap_rem     <= 7'd0;
         parity_acc  <= 8'd0;
         tmo_cnt     <= 8'd0;
         pkt_cnt_q   <= 16'd0;
         err_cnt_q   <= 8'd0;
         byte_valid  <= 1'b0;
         byte_data   <= 8'd0;
         byte_last   <= 1'b0;
         err_parity  <= 1'b0;
         err_addr    <= 1'b0;
         err_len     <= 1'b0;
         err_timeout <= 1'b0;
         pkt_len     <= 6'd0;
      end else begin
         rd_d       <= read_enb_o;
         byte_valid <= 1'b0;
         byte_last  <= 1'b0;
         dly_cnt    <= state == IDLE ? 4'(START_DELAY) : state == DELAY ? dly_cnt - 4'd1 : dly_cnt;
         tmo_cnt    <= (tmo_act && !vld_out_i) ? tmo_cnt + 8'd1 : 8'd0;
         if (state == BODY && read_enb_o) issue_rem <= issue_rem - 7'd1;
         if (state == HDR_CAP) begin
            pkt_len     <= data_in[7:2];
            err_addr    <= data_in[1:0] != PORT_ID;
            err_len     <= data_in[7:2] == 6'd0;
            err_parity  <= 1'b0;
            err_timeout <= 1'b0;
            issue_rem   <= {1'b0, data_in[7:2]} + 7'd1;
            cap_rem     <= {1'b0, data_in[7:2]} + 7'd1;
            parity_acc  <= data_in;
            byte_valid  <= 1'b1;
            byte_data   <= data_in;
         end
         if (cap_body) begin
            byte_valid <= 1'b1;
            byte_data  <= data_in;
            cap_rem    <= cap_rem - 7'd1;
            if (cap_rem == 7'd1) begin
               byte_last  <= 1'b1;
               err_parity <= data_in != parity_acc;
            end else parity_acc <= parity_acc ^ data_in;
         end
         // a timeout ends the stream with a bare byte_last marker
         if (tmo_hit) begin
            err_timeout <= 1'b1;
            byte_last   <= 1'b1;
         end
         if (pkt_done) begin
            pkt_cnt_q <= pkt_count;
            err_cnt_q <= err_count;
         end
      end
endmodule

// File: tb/tb_router_rx_sink.sv
// tb_router_rx_sink: scoreboard bench for router_rx_sink behind a modelled router port FIFO
module tb_router_rx_sink;
   logic        clk = 1'b0;
   logic        resetn, vld_out_i, sink_ready, read_enb_o;
   logic        byte_valid, byte_last, pkt_done, pkt_ok;
   logic        err_parity, err_addr, err_len, err_timeout;
   logic [7:0]  data_in, byte_data, err_count;
   logic [5:0]  pkt_len;
   logic [15:0] pkt_count;
   typedef struct {
      logic       ok, par, adr, len, tmo;
      logic [5:0] plen;
      logic [15:0] pc;
      logic [7:0] ec;
   } pkt_t;
   logic [7:0] fifo[$];
   logic [8:0] exp_b[$];
   pkt_t       exp_pkt[$];
   int checks = 0, errors = 0, rd_cnt = 0, m_pkt = 0, m_err = 0, lowc = 0;
   bit vld_hold = 1'b0;
   always #5 clk = ~clk;
   router_rx_sink #(.PORT_ID(2'd1), .START_DELAY(2), .TIMEOUT(64)) dut (
      .clk(clk), .resetn(resetn), .vld_out_i(vld_out_i), .data_in(data_in),
      .read_enb_o(read_enb_o), .sink_ready(sink_ready), .byte_valid(byte_valid),
      .byte_data(byte_data), .byte_last(byte_last), .pkt_done(pkt_done), .pkt_ok(pkt_ok),
      .err_parity(err_parity), .err_addr(err_addr), .err_len(err_len),
      .err_timeout(err_timeout), .pkt_len(pkt_len), .pkt_count(pkt_count), .err_count(err_count)
   );
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   task automatic cyc();
      @(negedge clk);
      vld_out_i = !vld_hold && fifo.size() != 0;
   endtask
   task automatic chk_zero(input string t);
      chk({t, "_flags"}, {read_enb_o, byte_valid, byte_last, pkt_done, pkt_ok,
                          err_parity, err_addr, err_len, err_timeout}, 0);
      chk({t, "_byte_data"}, byte_data, 0);
      chk({t, "_pkt_len"}, pkt_len, 0);
      chk({t, "_pkt_count"}, pkt_count, 0);
      chk({t, "_err_count"}, err_count, 0);
   endtask
   task automatic load_pkt(input logic [7:0] hdr, input logic [7:0] pmask, input int trunc);
      int n;
      logic [7:0] acc, b;
      logic lst;
      logic [7:0] bytes[$];
      pkt_t p;
      n   = int'(hdr[7:2]);
      acc = hdr;
      bytes.push_back(hdr);
      for (int i = 0; i < n; i++) begin
         b = 8'(i * 37) ^ hdr ^ 8'hA5;
         acc ^= b;
         bytes.push_back(b);
      end
      bytes.push_back(acc ^ pmask);
      if (trunc != 0) while (bytes.size() > trunc) void'(bytes.pop_back());
      for (int i = 0; i < bytes.size(); i++) begin
         lst = trunc == 0 && i == bytes.size() - 1;
         fifo.push_back(bytes[i]);
         exp_b.push_back({lst, bytes[i]});
      end
      p.tmo  = trunc != 0;
      p.par  = !p.tmo && pmask != 8'd0;
      p.adr  = hdr[1:0] != 2'd1;
      p.len  = hdr[7:2] == 6'd0;
      p.ok   = !(p.tmo | p.par | p.adr | p.len);
      p.plen = hdr[7:2];
      m_pkt++;
      if (!p.ok && m_err < 255) m_err++;
      p.pc = 16'(m_pkt);
      p.ec = 8'(m_err);
      exp_pkt.push_back(p);
      vld_out_i = !vld_hold && fifo.size() != 0;
   endtask
   task automatic wait_reads(input int base, input int n);
      int k = 0;
      while (rd_cnt - base < n && k < 100) begin cyc(); k++; end
      chk("reads_reached", k < 100, 1);
   endtask
   task automatic wait_done(input int bound, input int base, input int nreads);
      int k = 0;
      while ((exp_pkt.size() != 0 || exp_b.size() != 0) && k < bound) begin cyc(); k++; end
      chk("done_in_time", k < bound, 1);
      cyc();
      #1;
      chk("reads", rd_cnt - base, nreads);
      chk("pkt_count_hold", pkt_count, m_pkt);
      chk("err_count_hold", err_count, m_err);
      chk("idle_no_read", read_enb_o, 0);
   endtask
   // router port FIFO: data_out becomes valid the edge after read_enb
   initial forever begin
      @(posedge clk);
      if (!resetn) begin
         fifo.delete();
         data_in <= 8'h00;
      end else if (read_enb_o) begin
         chk("rd_vld", vld_out_i, 1);
         chk("rd_ready", sink_ready, 1);
         chk("rd_nonempty", fifo.size() != 0, 1);
         data_in <= fifo.size() != 0 ? fifo.pop_front() : 8'hEE;
         rd_cnt++;
      end
   end
   initial begin : monitor
      pkt_t p;
      forever begin
         @(posedge clk);
         #1;
         lowc = sink_ready ? 0 : lowc + 1;
         if (byte_valid && !sink_ready) chk("bp_trailing", lowc <= 1, 1);
         if (byte_valid) begin
            if (exp_b.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL byte_extra: got %0h expected no byte", byte_data);
            end else chk("byte", {byte_last, byte_data}, exp_b.pop_front());
         end
         if (pkt_done) begin
            if (exp_pkt.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL pkt_extra: got pkt_done expected none");
            end else begin
               p = exp_pkt.pop_front();
               chk("pkt_ok", pkt_ok, p.ok);
               chk("err_parity", err_parity, p.par);
               chk("err_addr", err_addr, p.adr);
               chk("err_len", err_len, p.len);
               chk("err_timeout", err_timeout, p.tmo);
               chk("pkt_len", pkt_len, p.plen);
               chk("pkt_count", pkt_count, p.pc);
               chk("err_count", err_count, p.ec);
               chk("done_last", byte_last, 1);
               chk("done_valid", byte_valid, !p.tmo);
            end
         end
      end
   end
   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1);
   end
   initial begin
      int base;
      resetn     = 1'b0;
      vld_out_i  = 1'b0;
      sink_ready = 1'b1;
      repeat (3) cyc();
      #1 chk_zero("reset");
      resetn = 1'b1;
      base = rd_cnt;
      load_pkt(8'h39, 8'h00, 0);
      cyc(); #1 chk("latency_d0", read_enb_o, 0);
      cyc(); #1 chk("latency_d1", read_enb_o, 0);
      cyc(); #1 chk("latency_hdr", read_enb_o, 1);
      wait_done(100, base, 16);
      base = rd_cnt;
      load_pkt(8'h21, 8'h01, 0);
      load_pkt(8'h21, 8'h00, 0);
      wait_done(200, base, 20);
      base = rd_cnt;
      load_pkt(8'h0A, 8'h00, 0);
      wait_done(100, base, 4);
      base = rd_cnt;
      load_pkt(8'h01, 8'h00, 0);
      wait_done(100, base, 2);
      base = rd_cnt;
      load_pkt(8'h45, 8'h00, 0);
      wait_reads(base, 6);
      vld_hold  = 1'b1;
      vld_out_i = 1'b0;
      repeat (5) begin
         #1 chk("stall_no_read", read_enb_o, 0);
         cyc();
      end
      vld_hold  = 1'b0;
      vld_out_i = fifo.size() != 0;
      wait_done(200, base, 19);
      base = rd_cnt;
      load_pkt(8'h21, 8'h00, 4);
      wait_done(300, base, 4);
      base = rd_cnt;
      load_pkt(8'h29, 8'h00, 0);
      wait_reads(base, 5);
      sink_ready = 1'b0;
      repeat (3) begin
         #1 chk("bp_no_read", read_enb_o, 0);
         cyc();
      end
      sink_ready = 1'b1;
      wait_done(200, base, 12);
      base = rd_cnt;
      load_pkt(8'h3D, 8'h00, 0);
      wait_reads(base, 6);
      resetn = 1'b0;
      exp_b.delete();
      exp_pkt.delete();
      m_pkt = 0;
      m_err = 0;
      cyc();
      #1 chk_zero("mid_reset");
      resetn = 1'b1;
      base = rd_cnt;
      load_pkt(8'h21, 8'h00, 0);
      wait_done(100, base, 10);
      repeat (3) cyc();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
